irq_timer_ctrl: RTL and testbench



---
 rtl/irq_timer_ctrl.sv | 154 +++++++++++++++
 tb/tb_irq_timer_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/irq_timer_ctrl.sv
// Memory-mapped interrupt/timer controller: pending/mask/edge registers, 32-bit timer, irq = pend & mask.
// Define IRQ_TIMER_EN to build the TCOUNT/TCMP/TCTRL timer; otherwise those registers read 0.
module irq_timer_ctrl #(
  parameter logic [31:0] CMP_RESET = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  wen,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [4:0]  irq_src,
  output logic [5:0]  irq
);

  localparam logic [7:0] A_PEND   = 8'd0;
  localparam logic [7:0] A_MASK   = 8'd1;
  localparam logic [7:0] A_EDGE   = 8'd2;
  localparam logic [7:0] A_TCOUNT = 8'd3;
  localparam logic [7:0] A_TCMP   = 8'd4;
  localparam logic [7:0] A_TCTRL  = 8'd5;
  localparam logic [7:0] A_SET    = 8'd6;

  logic [5:0]  pend_q, pend_d, mask_q, mask_d, irq_q, irq_d;
  logic [4:0]  edge_q, edge_d, src_q, src_d;
  logic [31:0] rdata_q, rdata_d;
  logic [5:0]  set_s, clr_s;
  logic [4:0]  event_s;
  logic        timer_match_s;
  logic [31:0] tcount_rd_s, tcmp_rd_s;
  logic [1:0]  tctrl_rd_s;

`ifdef IRQ_TIMER_EN
  logic [31:0] tcount_q, tcount_d, tcmp_q, tcmp_d;
  logic [1:0]  tctrl_q, tctrl_d;

  // Bus byte writes override the reload/increment value byte by byte.
  always_comb begin
    timer_match_s = tctrl_q[0] && (tcount_q == tcmp_q);
    tcount_d = tcount_q;
    tcmp_d   = tcmp_q;
    tctrl_d  = tctrl_q;
    if (tctrl_q[0]) begin
      if (timer_match_s && tctrl_q[1]) begin
        tcount_d = 32'd0;
      end else begin
        tcount_d = tcount_q + 32'd1;
      end
    end else begin
      tcount_d = tcount_q;
    end
    for (int b = 0; b < 4; b++) begin
      if (addr == A_TCOUNT && wen[b]) begin
        tcount_d[8*b +: 8] = wdata[8*b +: 8];
      end else begin
        tcount_d[8*b +: 8] = tcount_d[8*b +: 8];
      end
      if (addr == A_TCMP && wen[b]) begin
        tcmp_d[8*b +: 8] = wdata[8*b +: 8];
      end else begin
        tcmp_d[8*b +: 8] = tcmp_q[8*b +: 8];
      end
    end
    if (addr == A_TCTRL && wen[0]) begin
      tctrl_d = wdata[1:0];
    end else begin
      tctrl_d = tctrl_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tcount_q <= 32'd0;
      tcmp_q   <= CMP_RESET;
      tctrl_q  <= 2'd0;
    end else begin
      tcount_q <= tcount_d;
      tcmp_q   <= tcmp_d;
      tctrl_q  <= tctrl_d;
    end
  end

  assign tcount_rd_s = tcount_q;
  assign tcmp_rd_s   = tcmp_q;
  assign tctrl_rd_s  = tctrl_q;
`else
  logic unused_bus_s;
  assign unused_bus_s  = ^{wen[3:1], wdata[31:6], CMP_RESET};
  assign timer_match_s = 1'b0;
  assign tcount_rd_s   = 32'd0;
  assign tcmp_rd_s     = 32'd0;
  assign tctrl_rd_s    = 2'd0;
`endif

  // Event sets beat W1C clear; the read mux samples state before this cycle's write.
  always_comb begin
    event_s = (edge_q & irq_src & ~src_q) | (~edge_q & irq_src);
    set_s   = {timer_match_s, event_s};
    if (addr == A_SET && wen[0]) begin
      set_s = set_s | wdata[5:0];
    end else begin
      set_s = set_s;
    end
    if (addr == A_PEND && wen[0]) begin
      clr_s = wdata[5:0];
    end else begin
      clr_s = 6'd0;
    end
    pend_d = (pend_q & ~clr_s) | set_s;
    if (addr == A_MASK && wen[0]) begin
      mask_d = wdata[5:0];
    end else begin
      mask_d = mask_q;
    end
    if (addr == A_EDGE && wen[0]) begin
      edge_d = wdata[4:0];
    end else begin
      edge_d = edge_q;
    end
    src_d = irq_src;
    irq_d = pend_d & mask_d;
    case (addr)
      A_PEND:   rdata_d = {26'd0, pend_q};
      A_MASK:   rdata_d = {26'd0, mask_q};
      A_EDGE:   rdata_d = {27'd0, edge_q};
      A_TCOUNT: rdata_d = tcount_rd_s;
      A_TCMP:   rdata_d = tcmp_rd_s;
      A_TCTRL:  rdata_d = {30'd0, tctrl_rd_s};
      default:  rdata_d = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q  <= 6'd0;
      mask_q  <= 6'd0;
      edge_q  <= 5'd0;
      src_q   <= 5'd0;
      rdata_q <= 32'd0;
      irq_q   <= 6'd0;
    end else begin
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      edge_q  <= edge_d;
      src_q   <= src_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
    end
  end

  assign rdata = rdata_q;
  assign irq   = irq_q;

endmodule

// File: tb/tb_irq_timer_ctrl.sv
// Self-checking bench for irq_timer_ctrl: directed scenarios with literal expectations plus
// randomized bus/source traffic compared every cycle against a register-level model.
module tb_irq_timer_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  wen;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [4:0]  irq_src;
  logic [5:0]  irq;

`ifdef IRQ_TIMER_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif

  always #5 clk = ~clk;

  irq_timer_ctrl dut (
    .clk(clk), .reset(reset), .wen(wen), .addr(addr), .wdata(wdata),
    .rdata(rdata), .irq_src(irq_src), .irq(irq)
  );

  int checks = 0;
  int passed = 0;

  // Model state: the software-visible registers plus the delayed source copy.
  logic [5:0]  m_pend = 6'd0, m_mask = 6'd0;
  logic [4:0]  m_edge = 5'd0, m_src = 5'd0;
  logic [31:0] m_cnt = 32'd0, m_cmp = 32'd0, m_rdata = 32'd0;
  logic [1:0]  m_ctl = 2'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] mread(input logic [7:0] a);
    case (a)
      8'd0: return {26'd0, m_pend};
      8'd1: return {26'd0, m_mask};
      8'd2: return {27'd0, m_edge};
      8'd3: return TIMER ? m_cnt : 32'd0;
      8'd4: return TIMER ? m_cmp : 32'd0;
      8'd5: return TIMER ? {30'd0, m_ctl} : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // One bus cycle: drive, predict, clock, then compare the DUT with the model.
  task automatic cyc(input logic r, input logic [3:0] w, input logic [7:0] a,
                     input logic [31:0] d, input logic [4:0] s);
    logic [5:0] setb, clrb, np, nm;
    logic [4:0] ne;
    logic [31:0] nc, ncmp, nr;
    logic [1:0] nctl;
    logic match, ev;
    reset = r; wen = w; addr = a; wdata = d; irq_src = s;
    if (r) begin
      np = 6'd0; nm = 6'd0; ne = 5'd0; nc = 32'd0; ncmp = 32'hFFFF_FFFF; nctl = 2'd0; nr = 32'd0;
    end else begin
      nr = mread(a);
      setb = 6'd0;
      for (int i = 0; i < 5; i++) begin
        ev = m_edge[i] ? (s[i] && !m_src[i]) : s[i];
        if (ev) setb[i] = 1'b1;
      end
      match = TIMER && m_ctl[0] && (m_cnt == m_cmp);
      if (match) setb[5] = 1'b1;
      if (a == 8'd6 && w[0]) setb = setb | d[5:0];
      clrb = (a == 8'd0 && w[0]) ? d[5:0] : 6'd0;
      for (int i = 0; i < 6; i++)
        np[i] = setb[i] ? 1'b1 : (clrb[i] ? 1'b0 : m_pend[i]);
      nm = (a == 8'd1 && w[0]) ? d[5:0] : m_mask;
      ne = (a == 8'd2 && w[0]) ? d[4:0] : m_edge;
      nc = m_cnt;
      if (m_ctl[0]) nc = (match && m_ctl[1]) ? 32'd0 : m_cnt + 32'd1;
      ncmp = m_cmp;
      for (int b = 0; b < 4; b++) begin
        if (a == 8'd3 && w[b]) nc[8*b +: 8] = d[8*b +: 8];
        if (a == 8'd4 && w[b]) ncmp[8*b +: 8] = d[8*b +: 8];
      end
      nctl = (a == 8'd5 && w[0]) ? d[1:0] : m_ctl;
    end
    @(posedge clk);
    #1;
    m_pend = np; m_mask = nm; m_edge = ne; m_cnt = nc; m_cmp = ncmp; m_ctl = nctl;
    m_rdata = nr; m_src = r ? 5'd0 : s;
    check("model_rdata", rdata, m_rdata);
    check("model_irq", {26'd0, irq}, {26'd0, m_pend & m_mask});
  endtask

  initial begin
    logic [3:0] rw;
    logic [7:0] ra;
    logic [31:0] rd;
    int sel;

    // Reset and read back every defined register.
    cyc(1'b1, 4'h0, 8'd0, 32'd0, 5'd0);
    cyc(1'b1, 4'h0, 8'd0, 32'd0, 5'd0);
    check("rst_irq", {26'd0, irq}, 32'd0);
    for (int a = 0; a < 7; a++) begin
      cyc(1'b0, 4'h0, a[7:0], 32'd0, 5'd0);
      check("rst_read", rdata, (a == 4 && TIMER) ? 32'hFFFF_FFFF : 32'd0);
    end

    // Level source 0: W1C while high loses to set; clears once the line drops.
    cyc(1'b0, 4'h1, 8'd1, 32'h01, 5'd0);
    cyc(1'b0, 4'h1, 8'd2, 32'h00, 5'd0);
    for (int k = 0; k < 3; k++) cyc(1'b0, 4'h0, 8'd0, 32'd0, 5'h01);
    check("lvl_irq0_set", {31'd0, irq[0]}, 32'd1);
    cyc(1'b0, 4'h1, 8'd0, 32'h01, 5'h01);
    check("lvl_w1c_high", {31'd0, irq[0]}, 32'd1);
    cyc(1'b0, 4'h0, 8'd0, 32'd0, 5'h00);
    cyc(1'b0, 4'h1, 8'd0, 32'h01, 5'h00);
    check("lvl_w1c_low", {31'd0, irq[0]}, 32'd0);

    // Edge source 1 held high for 10 cycles, cleared once after 2.
    cyc(1'b0, 4'h1, 8'd2, 32'h02, 5'd0);
    cyc(1'b0, 4'h1, 8'd1, 32'h02, 5'd0);
    cyc(1'b0, 4'h0, 8'd0, 32'd0, 5'h02);
    check("edge_set", {31'd0, irq[1]}, 32'd1);
    cyc(1'b0, 4'h0, 8'd0, 32'd0, 5'h02);
    cyc(1'b0, 4'h1, 8'd0, 32'h02, 5'h02);
    for (int k = 0; k < 7; k++) cyc(1'b0, 4'h0, 8'd0, 32'd0, 5'h02);
    check("edge_once", {31'd0, irq[1]}, 32'd0);
    cyc(1'b0, 4'h0, 8'd0, 32'd0, 5'h00);

`ifdef IRQ_TIMER_EN
    // Reloading timer: TCMP=5, counts 0..5 then wraps back to 0.
    cyc(1'b0, 4'h1, 8'd0, 32'h3F, 5'd0);
    cyc(1'b0, 4'hF, 8'd4, 32'd5, 5'd0);
    cyc(1'b0, 4'h1, 8'd1, 32'h20, 5'd0);
    cyc(1'b0, 4'hF, 8'd3, 32'd0, 5'd0);
    cyc(1'b0, 4'h1, 8'd5, 32'd3, 5'd0);
    for (int k = 0; k < 8; k++) begin
      cyc(1'b0, 4'h0, 8'd3, 32'd0, 5'd0);
      check("tmr_count", rdata, (k <= 5) ? k : k - 6);
      check("tmr_irq5", {31'd0, irq[5]}, (k >= 5) ? 32'd1 : 32'd0);
    end
    cyc(1'b0, 4'h1, 8'd5, 32'd0, 5'd0);
    cyc(1'b0, 4'h1, 8'd0, 32'h20, 5'd0);
    // Free-running wrap: 0xFFFFFFFF -> 0, match at 3.
    cyc(1'b0, 4'hF, 8'd4, 32'd3, 5'd0);
    cyc(1'b0, 4'hF, 8'd3, 32'hFFFF_FFFF, 5'd0);
    cyc(1'b0, 4'h1, 8'd5, 32'd1, 5'd0);
    for (int k = 0; k < 6; k++) begin
      cyc(1'b0, 4'h0, 8'd3, 32'd0, 5'd0);
      check("wrap_count", rdata, (k == 0) ? 32'hFFFF_FFFF : k - 1);
      check("wrap_irq5", {31'd0, irq[5]}, (k >= 4) ? 32'd1 : 32'd0);
    end
    cyc(1'b0, 4'h1, 8'd5, 32'd0, 5'd0);
`else
    // Without the timer, timer registers ignore writes and pend[5] comes only from SET.
    cyc(1'b0, 4'hF, 8'd4, 32'd7, 5'd0);
    cyc(1'b0, 4'h0, 8'd4, 32'd0, 5'd0);
    check("notmr_tcmp", rdata, 32'd0);
`endif

    // SET write reads 0; PEND read then shows 0x3F; W1C read returns the old value.
    cyc(1'b0, 4'h1, 8'd1, 32'h3F, 5'd0);
    cyc(1'b0, 4'h1, 8'd0, 32'h3F, 5'd0);
    cyc(1'b0, 4'h1, 8'd6, 32'h3F, 5'd0);
    check("set_read0", rdata, 32'd0);
    check("set_irq", {26'd0, irq}, 32'h3F);
    cyc(1'b0, 4'h1, 8'd0, 32'h01, 5'd0);
    check("pend_old", rdata, 32'h3F);
    cyc(1'b0, 4'h0, 8'd0, 32'd0, 5'd0);
    check("pend_new", rdata, 32'h3E);

    // Reset mid-operation returns everything to reset values.
    cyc(1'b1, 4'h0, 8'd0, 32'd0, 5'd0);
    check("midrst_rdata", rdata, 32'd0);
    check("midrst_irq", {26'd0, irq}, 32'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      sel = $urandom_range(0, 99);
      ra = (sel < 90) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(8, 255));
      rw = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      rd = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      if (ra == 8'd0 && $urandom_range(0, 3) != 0) rw = 4'h0;
      cyc(($urandom_range(0, 299) == 0), rw, ra, rd, 5'($urandom));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
